odd_parity_serial_checker: RTL and testbench
============================================

Name: odd_parity_serial_checker

Overview:
- Receive-side counterpart of the team's odd parity generator.
- Deserialises a framed bit stream: start bit, DATA_W data bits LSB first, odd parity bit, stop bit.
- Checks odd parity and framing, then presents the recovered word with status flags.
- Keeps a saturating error counter. Sits between a bit-rate strobe source and downstream word consumers.

Parameters:
- DATA_W, 4, data bits per frame (>=1).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_en  in  1  bit strobe; rx_bit is sampled only on cycles where bit_en=1.
- rx_bit  in  1  serial line, idle high.
- err_cnt_clr  in  1  synchronous clear of err_cnt.
- data_out  out  DATA_W  last received word, held until the next frame completes.
- out_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  status of last frame: 1 = parity mismatch; held with data_out.
- frame_err  out  1  status of last frame: 1 = stop bit was 0; held with data_out.
- busy  out  1  high while not in IDLE.
- err_cnt  out  CNT_W  count of frames with parity_err or frame_err; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - data_out=0, out_valid=0, parity_err=0, frame_err=0, busy=0, err_cnt=0.
  - Shift register, bit counter and running XOR are cleared.
  - Reset asserted mid-frame aborts the frame; no out_valid is produced.
- All state advances only on bit_en=1, except that out_valid deasserts and err_cnt_clr acts every cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on bit_en with rx_bit=0 (start bit), go to DATA and clear the bit counter and XOR. A 1 stays in IDLE.
  - DATA: on each bit_en, shift rx_bit into the MSB end (LSB-first reassembly) and XOR it into the running parity. After DATA_W bits, go to PARITY.
  - PARITY: on bit_en, latch p_ok = running_xor ^ rx_bit. Odd parity is satisfied when p_ok=1. Go to STOP.
  - STOP: on bit_en, go to IDLE, and in the same edge:
    - data_out <= shift register.
    - parity_err <= ~p_ok.
    - frame_err <= ~rx_bit.
    - out_valid <= 1 for exactly one cycle.
- Latency: out_valid is high in the cycle after the edge that samples the stop bit.
- Frame with stop=0: it is still delivered (out_valid=1, data_out updated, frame_err=1). The FSM returns to IDLE; there is no break detection.
- bit_en gaps of any length inside a frame are legal; state holds.
- bit_en high every cycle is legal; back-to-back frames need no idle bit.
- err_cnt:
  - Increments by 1 on the out_valid-producing edge if parity_err or frame_err is set. A frame with both errors counts as 1.
  - Saturates at 2^CNT_W-1.
  - err_cnt_clr wins over a simultaneous increment (result 0).
- busy = (state != IDLE), registered.

Decomposition:
- Shared package odd_parity_pkg:
  - State enum (IDLE, DATA, PARITY, STOP).
  - Constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - Function odd_parity_bit(data) = ~^data, also used by the generator side and benches.
- One natural sub-module: sat_counter (CNT_W, inc, clr, count) for err_cnt.
- The FSM and shift path stay in the top level.

Test Plan:
- Good frame: bit_en every cycle; send start 0, data 4'b0000 (bits 0,0,0,0), parity 1, stop 1 -> one cycle later: out_valid=1, data_out=4'h0, parity_err=0, frame_err=0, err_cnt=0.
- All 16 words: for each value v=0..15 send its parity bit = ~^v with stop=1 -> 16 out_valid pulses; data_out=v each time; no errors; err_cnt=0. Repeat with 0-3 idle cycles of bit_en=0 randomly inserted between bits -> identical results.
- Parity error: data 4'b0110 with parity 0 -> parity_err=1, frame_err=0, err_cnt=1. Next frame 4'b1011 with parity 0 -> parity_err=0, err_cnt stays 1.
- Framing error: data 4'h5 with parity 1 and stop 0 -> out_valid=1, data_out=4'h5, frame_err=1, parity_err=0, err_cnt +1. The following frame decodes normally.
- Reset mid-frame: assert rst_n=0 after 2 data bits -> all outputs 0 and busy=0 immediately (async). Release, send a full good frame 4'hA with parity 1 -> data_out=4'hA with no spurious earlier out_valid.
- Counter edges (CNT_W=2): send 4 bad frames -> err_cnt=3 and stays 3. Assert err_cnt_clr on the same cycle as a bad frame's update -> err_cnt=0.

Source files
------------

// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd parity serial link.
// Used by the receive checker, the generator side and benches.
package odd_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Parity bit that makes data plus parity hold an odd number of ones.
    // Zero-extension of narrower words leaves the result unchanged.
    function automatic logic odd_parity_bit(input logic [63:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/odd_parity_serial_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over a simultaneous increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at all-ones, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/odd_parity_serial_checker.sv
// Receive-side odd parity checker: deserialises start/data/parity/stop
// frames, flags parity and framing errors, and counts bad frames.
module odd_parity_serial_checker
    import odd_parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_bit,
    input  logic              err_cnt_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic [BC_W-1:0]   cnt_q;
    logic [BC_W-1:0]   cnt_nxt;
    logic              xor_q;
    logic              xor_nxt;
    logic              pok_q;
    logic              pok_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              perr_nxt;
    logic              ferr_nxt;
    logic              err_inc;

    // State, shift path and held output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            xor_q      <= 1'b0;
            pok_q      <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            cnt_q      <= cnt_nxt;
            xor_q      <= xor_nxt;
            pok_q      <= pok_nxt;
            data_out   <= data_nxt;
            out_valid  <= valid_nxt;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

    // Frame sequencing; nothing moves without a bit strobe.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        xor_nxt   = xor_q;
        pok_nxt   = pok_q;
        data_nxt  = data_out;
        perr_nxt  = parity_err;
        ferr_nxt  = frame_err;
        valid_nxt = 1'b0;
        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (rx_bit == START_BIT) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        xor_nxt   = 1'b0;
                    end
                end
                DATA: begin
                    shift_nxt = shift_q >> 1;
                    shift_nxt[DATA_W-1] = rx_bit;
                    xor_nxt = xor_q ^ rx_bit;
                    if (cnt_q == LAST_BIT) begin
                        state_nxt = PARITY;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    pok_nxt   = xor_q ^ rx_bit;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    data_nxt  = shift_q;
                    perr_nxt  = ~pok_q;
                    ferr_nxt  = (rx_bit != STOP_BIT);
                    valid_nxt = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // A frame with either error counts once.
    always_comb begin
        err_inc = valid_nxt & (perr_nxt | ferr_nxt);
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .clr  (err_cnt_clr),
        .count(err_cnt)
    );

endmodule

// File: tb/tb_odd_parity_serial_checker.sv
// Directed bench for odd_parity_serial_checker with a frame scoreboard.
// Drives two instances (8-bit and 2-bit error counters) from one stream.
module tb_odd_parity_serial_checker;
    import odd_parity_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       rx_bit;
    logic       err_cnt_clr;
    logic [3:0] data_out;
    logic       out_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_cnt;
    logic [3:0] data_out2;
    logic       out_valid2;
    logic       parity_err2;
    logic       frame_err2;
    logic       busy2;
    logic [1:0] err_cnt2;

    typedef struct {
        logic [3:0] data;
        logic       perr;
        logic       ferr;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m8 = 0;
    int   m2 = 0;
    int   pushed = 0;
    int   pulses = 0;

    odd_parity_serial_checker #(
        .DATA_W(4),
        .CNT_W (8)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .rx_bit     (rx_bit),
        .err_cnt_clr(err_cnt_clr),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    odd_parity_serial_checker #(
        .DATA_W(4),
        .CNT_W (2)
    ) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .rx_bit     (rx_bit),
        .err_cnt_clr(err_cnt_clr),
        .data_out   (data_out2),
        .out_valid  (out_valid2),
        .parity_err (parity_err2),
        .frame_err  (frame_err2),
        .busy       (busy2),
        .err_cnt    (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int maxgap,
                            input logic clr);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            bit_en      = 1'b0;
            rx_bit      = IDLE_LEVEL;
            err_cnt_clr = 1'b0;
            tick();
        end
        bit_en      = 1'b1;
        rx_bit      = b;
        err_cnt_clr = clr;
        tick();
        bit_en      = 1'b0;
        err_cnt_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p,
                              input logic s, input int maxgap,
                              input logic clr);
        exp_t e;
        logic bad;
        e.data = d;
        e.perr = (p != odd_parity_bit(64'(d)));
        e.ferr = (s != STOP_BIT);
        bad    = e.perr | e.ferr;
        if (clr) begin
            m8 = 0;
            m2 = 0;
        end else if (bad) begin
            if (m8 < 255) m8++;
            if (m2 < 3) m2++;
        end
        e.c8 = 8'(m8);
        e.c2 = 2'(m2);
        sb.push_back(e);
        pushed++;
        send_bit(START_BIT, maxgap, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], maxgap, 1'b0);
        send_bit(p, maxgap, 1'b0);
        send_bit(s, maxgap, clr);
        check("latency_valid", 64'(out_valid), 64'd1);
    endtask

    // Scoreboard: each out_valid pulse pops and compares one frame.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("data_out", 64'(data_out), 64'(e.data));
                check("parity_err", 64'(parity_err), 64'(e.perr));
                check("frame_err", 64'(frame_err), 64'(e.ferr));
                check("err_cnt", 64'(err_cnt), 64'(e.c8));
                check("err_cnt2", 64'(err_cnt2), 64'(e.c2));
                check("busy_at_valid", 64'(busy), 64'd0);
                check("valid2", 64'(out_valid2), 64'd1);
                check("data_out2", 64'(data_out2), 64'(e.data));
                check("parity_err2", 64'(parity_err2), 64'(e.perr));
                check("frame_err2", 64'(frame_err2), 64'(e.ferr));
                check("busy2", 64'(busy2), 64'd0);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bit_en      = 1'b0;
        rx_bit      = IDLE_LEVEL;
        err_cnt_clr = 1'b0;
        #12;
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_perr", 64'(parity_err), 64'd0);
        check("rst_ferr", 64'(frame_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Idle-level bits must not start a frame.
        repeat (3) send_bit(IDLE_LEVEL, 0, 1'b0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(out_valid), 64'd0);

        // Basic good frame, back to back strobes.
        send_frame(4'h0, 1'b1, 1'b1, 0, 1'b0);
        check("after_start_busy", 64'(busy), 64'd0);

        // All words, no gaps, then with random gaps.
        for (int v = 0; v < 16; v++)
            send_frame(4'(v), odd_parity_bit(64'(v)), 1'b1, 0, 1'b0);
        for (int v = 0; v < 16; v++)
            send_frame(4'(v), odd_parity_bit(64'(v)), 1'b1, 3, 1'b0);

        // Parity error, then a clean frame with parity 0.
        send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b0);
        send_frame(4'b1011, 1'b0, 1'b1, 0, 1'b0);

        // Framing error, then a normal frame.
        send_frame(4'h5, 1'b1, 1'b0, 0, 1'b0);
        send_frame(4'h3, 1'b1, 1'b1, 1, 1'b0);

        // Both errors in one frame count once.
        send_frame(4'h1, 1'b1, 1'b0, 0, 1'b0);

        // Reset in the middle of a frame.
        send_bit(START_BIT, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        check("mid_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        m8 = 0;
        m2 = 0;
        check("mrst_data", 64'(data_out), 64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_perr", 64'(parity_err), 64'd0);
        check("mrst_ferr", 64'(frame_err), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_cnt", 64'(err_cnt), 64'd0);
        check("mrst_cnt2", 64'(err_cnt2), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send_frame(4'hA, 1'b1, 1'b1, 0, 1'b0);

        // Saturation of the narrow counter.
        repeat (4) send_frame(4'h6, 1'b0, 1'b1, 0, 1'b0);
        send_frame(4'h9, 1'b1, 1'b1, 0, 1'b0);

        // Clear coinciding with a bad frame's update.
        send_frame(4'hC, 1'b0, 1'b0, 0, 1'b1);
        send_frame(4'h2, 1'b0, 1'b1, 2, 1'b0);

        // Clear while idle.
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        m8 = 0;
        m2 = 0;
        check("idle_clr_cnt", 64'(err_cnt), 64'd0);
        check("idle_clr_cnt2", 64'(err_cnt2), 64'd0);

        repeat (4) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("pulse_count", 64'(pulses), 64'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
